// File: rtl/sext_arbiter_if.sv
// Request/result bundle shared by the sign-extension arbiter and its users.
// cnt_a/cnt_b exist only when SEXT_ARB_STATS_EN is defined.
interface sext_arbiter_if #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
);
  logic             req_a;
  logic [IN_W-1:0]  imm_a;
  logic             gnt_a;
  logic             req_b;
  logic [IN_W-1:0]  imm_b;
  logic             gnt_b;
  logic             res_valid;
  logic             res_id;
  logic [OUT_W-1:0] res;
  logic             res_ready;

  if (OUT_W <= IN_W || CNT_W < 1) begin : g_bad_params
    $error("sext_arbiter_if: need OUT_W > IN_W and CNT_W >= 1");
  end

`ifdef SEXT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  modport master (
    output req_a, imm_a, req_b, imm_b, res_ready,
    input  gnt_a, gnt_b, res_valid, res_id, res, cnt_a, cnt_b
  );
  modport slave (
    input  req_a, imm_a, req_b, imm_b, res_ready,
    output gnt_a, gnt_b, res_valid, res_id, res, cnt_a, cnt_b
  );
`else
  modport master (
    output req_a, imm_a, req_b, imm_b, res_ready,
    input  gnt_a, gnt_b, res_valid, res_id, res
  );
  modport slave (
    input  req_a, imm_a, req_b, imm_b, res_ready,
    output gnt_a, gnt_b, res_valid, res_id, res
  );
`endif
endinterface

// File: rtl/sext_arbiter.sv
// Two-requester round-robin arbiter feeding a single sign-extension result register.
// Optional saturating grant counters are built when SEXT_ARB_STATS_EN is defined.
module sext_arbiter #(
  parameter int IN_W  = 15,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  sext_arbiter_if.slave bus
);
  logic             r_valid;
  logic             r_id;
  logic             r_last_b;
  logic [OUT_W-1:0] r_res;

  logic             w_free;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic [OUT_W-1:0] w_ext_a;
  logic [OUT_W-1:0] w_ext_b;
  logic             w_valid_nxt;
  logic             w_id_nxt;
  logic             w_last_b_nxt;
  logic [OUT_W-1:0] w_res_nxt;

  if (OUT_W <= IN_W || CNT_W < 1) begin : g_bad_params
    $error("sext_arbiter: need OUT_W > IN_W and CNT_W >= 1");
  end

  // Slot is free when empty or being drained this cycle; reset suppresses grants.
  assign w_free  = ~r_valid | bus.res_ready;
  assign w_gnt_a = ~rst & w_free & bus.req_a & (~bus.req_b | r_last_b);
  assign w_gnt_b = ~rst & w_free & bus.req_b & (~bus.req_a | ~r_last_b);

  assign w_ext_a = {{(OUT_W-IN_W){bus.imm_a[IN_W-1]}}, bus.imm_a};
  assign w_ext_b = {{(OUT_W-IN_W){bus.imm_b[IN_W-1]}}, bus.imm_b};

  always_comb begin
    w_valid_nxt  = r_valid;
    w_id_nxt     = r_id;
    w_last_b_nxt = r_last_b;
    w_res_nxt    = r_res;
    if (w_gnt_a) begin
      w_valid_nxt  = 1'b1;
      w_id_nxt     = 1'b0;
      w_last_b_nxt = 1'b0;
      w_res_nxt    = w_ext_a;
    end else if (w_gnt_b) begin
      w_valid_nxt  = 1'b1;
      w_id_nxt     = 1'b1;
      w_last_b_nxt = 1'b1;
      w_res_nxt    = w_ext_b;
    end else if (r_valid && bus.res_ready) begin
      w_valid_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_id     <= 1'b0;
      r_last_b <= 1'b1;
      r_res    <= '0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_id     <= w_id_nxt;
      r_last_b <= w_last_b_nxt;
      r_res    <= w_res_nxt;
    end
  end

  assign bus.gnt_a     = w_gnt_a;
  assign bus.gnt_b     = w_gnt_b;
  assign bus.res_valid = r_valid;
  assign bus.res_id    = r_id;
  assign bus.res       = r_res;

`ifdef SEXT_ARB_STATS_EN
  logic [1:0]            w_gnt_vec;
  logic [1:0][CNT_W-1:0] r_cnt;

  assign w_gnt_vec = {w_gnt_b, w_gnt_a};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt[gi] <= '0;
      end else if (w_gnt_vec[gi] && (r_cnt[gi] != {CNT_W{1'b1}})) begin
        r_cnt[gi] <= r_cnt[gi] + 1'b1;
      end
    end
  end

  assign bus.cnt_a = r_cnt[0];
  assign bus.cnt_b = r_cnt[1];
`endif
endmodule
